// File: rtl/mul_div_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit.
package mul_div_iter_pkg;

    localparam logic [1:0] MD_OP_DIV = 2'b01;
    localparam logic [1:0] MD_OP_MUL = 2'b11;

    localparam logic [1:0] MD_IDLE = 2'b00;
    localparam logic [1:0] MD_BUSY = 2'b01;
    localparam logic [1:0] MD_DONE = 2'b10;

    localparam int unsigned MD_STEPS = 32;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative 32-bit multiply/divide: one shift-add or restoring-divide step per cycle.
module mul_div_iter
    import mul_div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = MD_STEPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           choose_x,
    input  logic                 dm_signed,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned WRK_W = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Conditional two's-complement negate; 0x8000_0000 maps onto itself.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic [1:0]           state,    state_nxt;
    logic [CNT_W-1:0]     cnt,      cnt_nxt;
    logic [WRK_W-1:0]     work,     work_nxt;
    logic [WIDTH-1:0]     op2_r,    op2_nxt;
    logic                 is_mul,   is_mul_nxt;
    logic                 sgn_q,    sgn_q_nxt;
    logic                 sgn_r,    sgn_r_nxt;
    logic                 dz,       dz_nxt;
    logic                 ready_nxt;
    logic [2*WIDTH-1:0]   result_nxt;

    logic [WIDTH:0]       acc_sum;
    logic [WIDTH+1:0]     trial;
    logic [WRK_W-1:0]     shl;
    logic [WRK_W-1:0]     step_nxt;
    logic [2*WIDTH-1:0]   final_val;
    logic                 req;
    logic                 s1, s2;

    // One iteration of the selected algorithm on the working register.
    always_comb begin
        acc_sum = work[2*WIDTH:WIDTH];
        if (work[0]) begin
            acc_sum = work[2*WIDTH:WIDTH] + {1'b0, op2_r};
        end
        shl   = {work[2*WIDTH-1:0], 1'b0};
        trial = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, op2_r};
        if (is_mul) begin
            step_nxt = {1'b0, acc_sum, work[WIDTH-1:1]};
        end else if (trial[WIDTH+1]) begin
            step_nxt = shl;
        end else begin
            step_nxt = {trial[WIDTH:0], shl[WIDTH-1:1], 1'b1};
        end
    end

    // Sign-corrected result from the state after the final step.
    always_comb begin
        if (is_mul) begin
            final_val = neg_2w(step_nxt[2*WIDTH-1:0], sgn_q);
        end else if (dz) begin
            final_val = {neg_w(step_nxt[2*WIDTH-1:WIDTH], sgn_r), {WIDTH{1'b1}}};
        end else begin
            final_val = {neg_w(step_nxt[2*WIDTH-1:WIDTH], sgn_r),
                         neg_w(step_nxt[WIDTH-1:0], sgn_q)};
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        work_nxt   = work;
        op2_nxt    = op2_r;
        is_mul_nxt = is_mul;
        sgn_q_nxt  = sgn_q;
        sgn_r_nxt  = sgn_r;
        dz_nxt     = dz;
        ready_nxt  = 1'b0;
        result_nxt = result_o;

        req = start_i && !annul_i && (choose_x == MD_OP_DIV || choose_x == MD_OP_MUL);
        s1  = dm_signed & opdata1_i[WIDTH-1];
        s2  = dm_signed & opdata2_i[WIDTH-1];

        case (state)
            MD_IDLE: begin
                if (req) begin
                    is_mul_nxt = (choose_x == MD_OP_MUL);
                    sgn_q_nxt  = s1 ^ s2;
                    sgn_r_nxt  = s1;
                    dz_nxt     = (choose_x == MD_OP_DIV) && (opdata2_i == '0);
                    cnt_nxt    = '0;
                    if (choose_x == MD_OP_MUL) begin
                        work_nxt = {(WIDTH+1)'(0), neg_w(opdata2_i, s2)};
                        op2_nxt  = neg_w(opdata1_i, s1);
                    end else begin
                        work_nxt = {(WIDTH+1)'(0), neg_w(opdata1_i, s1)};
                        op2_nxt  = neg_w(opdata2_i, s2);
                    end
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (annul_i || !start_i) begin
                    state_nxt = MD_IDLE;
                end else begin
                    work_nxt = step_nxt;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        result_nxt = final_val;
                        ready_nxt  = 1'b1;
                        state_nxt  = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                state_nxt = MD_IDLE;
            end
            default: begin
                state_nxt = MD_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            work     <= '0;
            op2_r    <= '0;
            is_mul   <= 1'b0;
            sgn_q    <= 1'b0;
            sgn_r    <= 1'b0;
            dz       <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            work     <= work_nxt;
            op2_r    <= op2_nxt;
            is_mul   <= is_mul_nxt;
            sgn_q    <= sgn_q_nxt;
            sgn_r    <= sgn_r_nxt;
            dz       <= dz_nxt;
            ready_o  <= ready_nxt;
            result_o <= result_nxt;
        end
    end

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed bench for mul_div_iter: vector table plus abort/reset/back-to-back sequences.
module tb_mul_div_iter;
    import mul_div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [1:0]  choose_x;
    logic        dm_signed;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    mul_div_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .choose_x  (choose_x),
        .dm_signed (dm_signed),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edges until ready_o is seen high (1 = first edge); -1 on timeout.
    task automatic wait_ready(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (ready_o) n++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        choose_x  = op;
        dm_signed = sgn;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        start_i   = 1'b1;
    endtask

    // Release start after a completion and confirm the pulse is one cycle wide.
    task automatic end_op(input string name, input logic [63:0] held);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " ready_drop"}, 64'(ready_o), 64'd0);
        check({name, " result_hold"}, result_o, held);
    endtask

    initial begin
        int lat;
        int n;
        logic [63:0] last;

        vecs[0]  = '{MD_OP_MUL, 1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
        vecs[1]  = '{MD_OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{MD_OP_DIV, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E};
        vecs[3]  = '{MD_OP_DIV, 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
        vecs[4]  = '{MD_OP_DIV, 1'b1, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF};
        vecs[5]  = '{MD_OP_DIV, 1'b1, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF};
        vecs[6]  = '{MD_OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[7]  = '{MD_OP_MUL, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[8]  = '{MD_OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        vecs[9]  = '{MD_OP_MUL, 1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
        vecs[10] = '{MD_OP_DIV, 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[11] = '{MD_OP_DIV, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002};
        vecs[12] = '{MD_OP_DIV, 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF};
        vecs[13] = '{MD_OP_DIV, 1'b1, 32'h80000000, 32'h00000002, 64'h00000000_C0000000};
        vecs[14] = '{MD_OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000};
        vecs[15] = '{MD_OP_MUL, 1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000};
        vecs[16] = '{MD_OP_DIV, 1'b0, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF};
        vecs[17] = '{MD_OP_MUL, 1'b1, 32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; choose_x = 2'b00;
        dm_signed = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: latency, value, pulse width; operands are scrambled after the request edge.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            check($sformatf("vec%0d early_ready", i), 64'(ready_o), 64'd0);
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            dm_signed = ~dm_signed;
            wait_ready(40, lat);
            if (lat > 0) lat = lat + 1;
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d result", i), result_o, vecs[i].exp);
            end_op($sformatf("vec%0d", i), vecs[i].exp);
        end
        last = vecs[NVEC-1].exp;

        // No-op selects never start an operation.
        issue(2'b00, 1'b0, 32'd6, 32'd7);
        count_ready(40, n);
        check("noop00 ready_count", 64'(n), 64'd0);
        issue(2'b10, 1'b0, 32'd6, 32'd7);
        count_ready(40, n);
        check("noop10 ready_count", 64'(n), 64'd0);
        check("noop result_hold", result_o, last);

        // Abort by dropping start in cycle N+10.
        issue(MD_OP_MUL, 1'b0, 32'd1000, 32'd1000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        count_ready(40, n);
        check("abort_start ready_count", 64'(n), 64'd0);
        check("abort_start result_hold", result_o, last);

        // Fresh request right after an abort has normal latency.
        issue(MD_OP_MUL, 1'b0, 32'd3, 32'd4);
        wait_ready(40, lat);
        check("post_abort latency", 64'(lat), 64'd33);
        check("post_abort result", result_o, 64'd12);
        end_op("post_abort", 64'd12);
        last = 64'd12;

        // Abort by a one-cycle annul pulse in cycle N+10 with start still high.
        issue(MD_OP_DIV, 1'b0, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        count_ready(40, n);
        check("abort_annul ready_count", 64'(n), 64'd0);
        check("abort_annul result_hold", result_o, last);

        // Start and annul together in IDLE: no request until annul falls.
        issue(MD_OP_DIV, 1'b0, 32'd9, 32'd2);
        annul_i = 1'b1;
        count_ready(40, n);
        check("idle_annul ready_count", 64'(n), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        wait_ready(40, lat);
        check("idle_annul_release latency", 64'(lat), 64'd33);
        check("idle_annul_release result", result_o, 64'h00000001_00000004);
        end_op("idle_annul_release", 64'h00000001_00000004);

        // Back-to-back MULTs with start held throughout.
        issue(MD_OP_MUL, 1'b1, 32'hFFFFFFFE, 32'h00000003);
        wait_ready(40, lat);
        check("b2b first latency", 64'(lat), 64'd33);
        check("b2b first result", result_o, 64'hFFFFFFFF_FFFFFFFA);
        @(negedge clk);
        opdata1_i = 32'h00010000;
        opdata2_i = 32'h00010000;
        dm_signed = 1'b0;
        wait_ready(40, lat);
        check("b2b second spacing", 64'(lat), 64'd34);
        check("b2b second result", result_o, 64'h00000001_00000000);
        end_op("b2b", 64'h00000001_00000000);

        // Synchronous reset in the middle of BUSY.
        issue(MD_OP_MUL, 1'b0, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset ready", 64'(ready_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        count_ready(40, n);
        check("midreset ready_count", 64'(n), 64'd0);
        check("midreset result_hold", result_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
